// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED bank arbiter.
// Optional build macro used by the top: LED_ARB_IDLE_BLINK_EN.
package led_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FORCE
  } arb_state_e;

  // Widest requester vector rr_pick can handle.
  localparam int unsigned MAX_REQ = 32;

  // Bits needed for a counter that holds values 0..cycles.
  function automatic int unsigned cnt_w(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

  // One-hot pick of the first set request, searching from ptr+1 and wrapping
  // over n requesters. The current pointer is searched last.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input int unsigned         ptr,
                                                 input int unsigned         n);
    logic [MAX_REQ-1:0] r;
    int unsigned        idx;
    r = '0;
    for (int unsigned k = 1; k <= n; k++) begin
      idx = (ptr + k) % n;
      if (r == '0 && req[idx[4:0]]) r[idx[4:0]] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/led_bank_arbiter_if.sv
// Requester/LED-side signal bundle of the LED bank arbiter.
interface led_bank_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned LED_W   = 2
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LED_W-1:0] req_led;
  logic [NUM_REQ-1:0]       gnt;
  logic [LED_W-1:0]         led_out;
  logic                     override;
  logic                     busy;

  modport master (output req, req_led, input gnt, led_out, override, busy);
  modport slave  (input req, req_led, output gnt, led_out, override, busy);
endinterface

// File: rtl/led_bank_arbiter_sw_debounce.sv
// Slide-switch debouncer: two-flop synchronizer followed by a stability
// counter; dout follows din only after DEB_CYCLES equal synchronized samples.
module sw_debounce
  import led_arb_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned DW = cnt_w(DEB_CYCLES);

  logic          s1;
  logic          s2;
  logic [DW-1:0] cnt;

  // Synchronize, then accept a new level once it has stayed put long enough.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) begin
        cnt <= '0;
      end else if (cnt == DW'(DEB_CYCLES - 1)) begin
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of a shared LED bank with a minimum hold time and a
// debounced switch override that forces requester 0.
// Build option: define LED_ARB_IDLE_BLINK_EN for an idle heartbeat on led_out[0].
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned LED_W       = 2,
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned DEB_CYCLES  = 500000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sw_raw,
  led_bank_arbiter_if.slave bus
);

  localparam int unsigned CW = cnt_w(HOLD_CYCLES);
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam logic [CW-1:0]      RELOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] GNT0   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic               override;
  arb_state_e         state;
  logic [NUM_REQ-1:0] gnt;
  logic [LED_W-1:0]   led_out;
  logic               busy;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      owner;
  logic [CW-1:0]      hold_cnt;
`ifdef LED_ARB_IDLE_BLINK_EN
  logic [CW-1:0]      blink_cnt;
`endif

  logic [LED_W-1:0]   slice [NUM_REQ];
  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] pick_full;
  logic [NUM_REQ-1:0] pick;
  logic               pick_any;
  logic [IW-1:0]      pick_idx;

  sw_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (sw_raw),
    .dout    (override)
  );

  // Split the packed pattern bus into per-requester slices.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      slice[i] = bus.req_led[i*LED_W +: LED_W];
    end
  end

  // Round-robin candidate from the current pointer, as one-hot and index.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = bus.req;
    pick_full              = rr_pick(req_ext, 32'(rr_ptr), NUM_REQ);
    pick                   = pick_full[NUM_REQ-1:0];
    pick_any               = |pick_full;
    pick_idx               = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IW'(i);
    end
  end

  // Arbitration FSM with registered grant, LED drive and busy flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      gnt      <= '0;
      led_out  <= '0;
      busy     <= 1'b0;
      rr_ptr   <= IW'(NUM_REQ - 1);
      owner    <= '0;
      hold_cnt <= '0;
`ifdef LED_ARB_IDLE_BLINK_EN
      blink_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (override) begin
            state <= FORCE;
            busy  <= 1'b1;
            gnt   <= GNT0;
            owner <= '0;
          end else if (pick_any) begin
            state    <= HOLD;
            busy     <= 1'b1;
            gnt      <= pick;
            owner    <= pick_idx;
            rr_ptr   <= pick_idx;
            hold_cnt <= RELOAD;
          end
`ifdef LED_ARB_IDLE_BLINK_EN
          else if (blink_cnt == RELOAD) begin
            blink_cnt  <= '0;
            led_out[0] <= ~led_out[0];
          end else begin
            blink_cnt <= blink_cnt + CW'(1);
          end
`endif
        end
        HOLD: begin
          if (override) begin
            state <= FORCE;
            gnt   <= GNT0;
            owner <= '0;
          end else begin
            // A requester that withdrew keeps its last pattern on the LEDs.
            if (bus.req[owner]) led_out <= slice[owner];
            if (hold_cnt == '0) begin
              if (pick_any) begin
                gnt      <= pick;
                owner    <= pick_idx;
                rr_ptr   <= pick_idx;
                hold_cnt <= RELOAD;
              end else begin
                state   <= IDLE;
                busy    <= 1'b0;
                gnt     <= '0;
                led_out <= '0;
`ifdef LED_ARB_IDLE_BLINK_EN
                blink_cnt <= '0;
`endif
              end
            end else begin
              hold_cnt <= hold_cnt - CW'(1);
            end
          end
        end
        FORCE: begin
          gnt     <= GNT0;
          owner   <= '0;
          led_out <= slice[0];
          // rr_ptr is left alone so the rotation resumes where it was.
          if (!override) begin
            state    <= HOLD;
            hold_cnt <= RELOAD;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          gnt   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt      = gnt;
  assign bus.led_out  = led_out;
  assign bus.busy     = busy;
  assign bus.override = override;

endmodule
